// File: rtl/cpc_upper_rom_select.sv
// cpc_upper_rom_select: snoops &DFxx upper-ROM select writes and gates ROMDIS/74245 enable for served slots.
// Optional build macro: T35_LOWER_ROM_EN adds the lowrom_sel strap and claims lower-ROM reads.
module cpc_upper_rom_select #(
  parameter logic [15:0] SLOT_MASK  = 16'h00FE,
  parameter int          SEL_STABLE = 2
) (
  input  logic       CLK,
  input  logic       RESET_B,
  input  logic       IOREQ_B,
  input  logic       WR_B,
  input  logic       RD_B,
  input  logic       MREQ_B,
  input  logic       ROMEN_B,
  input  logic       A15,
  input  logic       A14,
  input  logic       A13,
  input  logic [7:0] D,
`ifdef T35_LOWER_ROM_EN
  input  logic       lowrom_sel,
`endif
  output logic [7:0] rom_num,
  output logic       romvalid,
  output logic       romdis_pre,
  output logic       bufoe_b
);
  typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, LATCH = 2'd2} state_t;
  localparam logic [1:0] SEL_N = SEL_STABLE[1:0];
  state_t     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [1:0] sync_q;
  logic [7:0] rom_num_q, rom_num_d;
  logic       romvalid_q, romvalid_d;
  logic       romdis_q, romdis_d;
  logic       bufoe_q, bufoe_d;
  logic       run, iow, uprd, lowrd, cap;
  assign run  = sync_q[1];
  assign iow  = ~IOREQ_B & ~WR_B & ~A13;
  assign uprd = ~MREQ_B & ~RD_B & ~ROMEN_B & A15 & A14;
`ifdef T35_LOWER_ROM_EN
  assign lowrd = ~MREQ_B & ~RD_B & ~ROMEN_B & ~A15 & ~A14 & lowrom_sel;
`else
  assign lowrd = 1'b0;
`endif
  // reset release is resynchronised; state only advances once the stage has filled
  always_ff @(posedge CLK or negedge RESET_B)
    if (!RESET_B) sync_q <= 2'b00;
    else          sync_q <= {sync_q[0], 1'b1};
  // select FSM: count consecutive strobe samples, capture once when stable long enough
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap     = 1'b0;
    if (run)
      case (state_q)
        IDLE:
          if (iow) begin
            cnt_d   = 2'd1;
            cap     = (SEL_N == 2'd1);
            state_d = (SEL_N == 2'd1) ? LATCH : ARM;
          end
        ARM:
          if (iow) begin
            cnt_d   = cnt_q + 2'd1;
            cap     = (cnt_q + 2'd1 == SEL_N);
            state_d = (cnt_q + 2'd1 == SEL_N) ? LATCH : ARM;
          end else begin
            state_d = IDLE;
          end
        LATCH:   state_d = iow ? LATCH : IDLE;
        default: state_d = IDLE;
      endcase
  end
  // datapath next state: captured byte, slot ownership, read claim
  always_comb begin
    rom_num_d  = cap ? D : rom_num_q;
    romvalid_d = run ? ((rom_num_q < 8'd16) & SLOT_MASK[rom_num_q[3:0]]) : romvalid_q;
    romdis_d   = run ? (romdis_q ? (uprd | lowrd) : ((uprd & romvalid_q) | lowrd)) : romdis_q;
    bufoe_d    = ~romdis_d;
  end
  // all state registers; reset forces the bus released immediately
  always_ff @(posedge CLK or negedge RESET_B)
    if (!RESET_B) begin
      state_q    <= IDLE;
      cnt_q      <= 2'd0;
      rom_num_q  <= 8'h00;
      romvalid_q <= 1'b0;
      romdis_q   <= 1'b0;
      bufoe_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rom_num_q  <= rom_num_d;
      romvalid_q <= romvalid_d;
      romdis_q   <= romdis_d;
      bufoe_q    <= bufoe_d;
    end
  assign rom_num    = rom_num_q;
  assign romvalid   = romvalid_q;
  assign romdis_pre = romdis_q;
  assign bufoe_b    = bufoe_q;
endmodule
